// File: rtl/serial_feeder_pkg.sv
// Shared types and defaults for the serial_feeder parallel-to-serial front end.
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int   SF_W        = 8;
  localparam int   SF_DEPTH    = 4;
  localparam logic SF_IDLE_BIT = 1'b1;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_feeder_fifo.sv
// Word FIFO with registered read/write pointers; the head word is presented combinationally.
module serial_feeder_fifo
  import serial_feeder_pkg::*;
#(
  parameter int W     = SF_W,
  parameter int DEPTH = SF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

endmodule

// File: rtl/serial_feeder.sv
// Buffers words and shifts them out MSB-first, one bit per clk, with an idle level between frames.
// Define SERIAL_FEEDER_PARITY_EN to append one even-parity bit after every word.
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   W        = SF_W,
  parameter int   DEPTH    = SF_DEPTH,
  parameter logic IDLE_BIT = SF_IDLE_BIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         frame_start
);

  localparam int            CW       = clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t       state_q, state_d;
  logic [W-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         dout_q, dout_d;
  logic         dv_q, dv_d;
  logic         fs_q, fs_d;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic         parity_q, parity_d;
`endif

  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [W-1:0] head;
  logic         load;
  logic         go_idle;

  assign in_ready = !fifo_full;

  serial_feeder_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dout_q   <= IDLE_BIT;
      dv_q     <= 1'b0;
      fs_q     <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      fs_q     <= fs_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    fs_d     = 1'b0;
    fifo_pop = 1'b0;
    load     = 1'b0;
    go_idle  = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
        else             go_idle = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          dout_d  = shreg_q[W-1];
          shreg_d = {shreg_q[W-2:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
        end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
          dout_d  = parity_q;
          dv_d    = 1'b1;
          state_d = PARITY;
`else
          if (!fifo_empty) load = 1'b1;
          else             go_idle = 1'b1;
`endif
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      PARITY: begin
        if (!fifo_empty) load = 1'b1;
        else             go_idle = 1'b1;
      end
`endif
      default: go_idle = 1'b1;
    endcase

    // The MSB goes straight to dout, so the shifter only keeps the remaining W-1 bits.
    if (load) begin
      fifo_pop = 1'b1;
      dout_d   = head[W-1];
      dv_d     = 1'b1;
      fs_d     = 1'b1;
      shreg_d  = {head[W-2:0], 1'b0};
      cnt_d    = LAST_CNT;
      state_d  = SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d = ^head;
`endif
    end

    if (go_idle) begin
      dout_d  = IDLE_BIT;
      dv_d    = 1'b0;
      state_d = IDLE;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_serial_feeder.sv
// Scoreboard bench for serial_feeder: stimulus queues expected bits, a negedge monitor checks them.
module tb_serial_feeder;

  localparam int   W        = 8;
  localparam int   DEPTH    = 4;
  localparam logic IDLE_BIT = 1'b1;

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int          WORD_BITS = W + 1;
  localparam logic [31:0] EXP_B2B   = 32'({8'hAA, 1'b0, 8'h55, 1'b0});
  localparam int          EXP_HITS  = 6;
`else
  localparam int          WORD_BITS = W;
  localparam logic [31:0] EXP_B2B   = 32'h0000_AA55;
  localparam int          EXP_HITS  = 7;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         dout;
  logic         dout_valid;
  logic         frame_start;

  always #5 clk = ~clk;

  serial_feeder #(
    .W        (W),
    .DEPTH    (DEPTH),
    .IDLE_BIT (IDLE_BIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  bit   capture = 1'b0;
  logic obs_bits[$];
  logic obs_valid[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word becomes W bits MSB-first, first flagged as frame start, plus optional even parity.
  function automatic void model_push(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) sb.push_back('{b: d[i], fs: (i == W - 1)});
`ifdef SERIAL_FEEDER_PARITY_EN
    sb.push_back('{b: ^d, fs: 1'b0});
`endif
  endfunction

  function automatic logic [63:0] detect(input logic s[$]);
    logic [3:0]  win;
    logic [63:0] h;
    win = '0;
    h   = '0;
    for (int i = 0; i < s.size(); i++) begin
      win = {win[2:0], s[i]};
      if (i >= 3 && win == 4'b1010) h = h | (64'd1 << i);
    end
    return h;
  endfunction

  // Monitor: every valid bit must match the scoreboard head; idle cycles must show the idle level.
  always @(negedge clk) begin
    if (!rst) begin
      if (capture) obs_valid.push_back(dout_valid);
      if (dout_valid) begin
        if (capture) obs_bits.push_back(dout);
        if (sb.size() == 0) begin
          check("unexpected_bit", 32'(dout_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("dout_bit", 32'(dout), 32'(e.b));
          check("frame_start", 32'(frame_start), 32'(e.fs));
        end
      end else begin
        check("idle_level", 32'({dout, frame_start}), 32'({IDLE_BIT, 1'b0}));
      end
    end
  end

  // Call right after a negedge; returns on the negedge following acceptance with in_valid still high.
  task automatic send(input logic [W-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else           model_push(d);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n        = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || dout_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(sb.size() == 0 && !dout_valid), 32'd1);
  endtask

  initial begin
    logic        [31:0] val;
    logic        [63:0] h_obs, h_gold;
    logic               gold[$];
    logic        [W-1:0] w;
    int                 run;
    bit                 started;

    // Reset idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", 32'({dout, dout_valid, in_ready}), 32'({IDLE_BIT, 1'b0, 1'b1}));
    end

    // Single word with latency check
    send(8'hA5);
    in_valid = 1'b0;
    check("latency_pre", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("latency_first", 32'({dout, dout_valid, frame_start}), 32'(3'b111));
    drain();

    // Back-to-back words, contiguous valid bits
    obs_bits.delete();
    obs_valid.delete();
    capture = 1'b1;
    send(8'hAA);
    send(8'h55);
    drain();
    repeat (2) @(negedge clk);
    capture = 1'b0;
    run     = 0;
    started = 1'b0;
    for (int i = 0; i < obs_valid.size(); i++) begin
      if (obs_valid[i]) begin
        if (!started || run > 0) run++;
        started = 1'b1;
      end else if (started) begin
        break;
      end
    end
    check("b2b_run", 32'(run), 32'(2 * WORD_BITS));
    val = '0;
    for (int i = 0; i < obs_bits.size(); i++) val = {val[30:0], obs_bits[i]};
    check("b2b_bits", val, EXP_B2B);

    // Full FIFO: DEPTH+1 accepted immediately, then in_ready drops
    for (int k = 0; k < DEPTH + 1; k++) begin
      check("fill_ready", 32'(in_ready), 32'd1);
      send(W'(8'h10 + k));
    end
    check("full_not_ready", 32'(in_ready), 32'd0);
    send(8'h7E);
    drain();

    // Reset mid-word with words queued
    send(8'hF0);
    send(8'h3C);
    send(8'hC3);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async", 32'({dout, dout_valid, frame_start, in_ready}), 32'({IDLE_BIT, 3'b001}));
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_quiet", 32'(dout_valid), 32'd0);
    end

    // Detector integration: pattern 1010 flags on observed stream vs golden stream
    obs_bits.delete();
    obs_valid.delete();
    capture = 1'b1;
    send(8'hAA);
    send(8'hAA);
    drain();
    capture = 1'b0;
    gold.delete();
    for (int k = 0; k < 2; k++) begin
      w = 8'hAA;
      for (int i = W - 1; i >= 0; i--) gold.push_back(w[i]);
`ifdef SERIAL_FEEDER_PARITY_EN
      gold.push_back(^w);
`endif
    end
    h_obs  = detect(obs_bits);
    h_gold = detect(gold);
    check("det_flags_lo", h_obs[31:0], h_gold[31:0]);
    check("det_hits", 32'($countones(h_obs)), 32'(EXP_HITS));

    // Randomized traffic with random gaps
    for (int k = 0; k < 80; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send(W'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
